// File: rtl/vend_credit_ctrl.sv
// Vending credit sequencer: drives the external ALU to add coins, check and subtract prices, and refund.
// Coin to credit takes 1 cycle; select to vend takes 2; requests arriving while busy are dropped, not queued.
module vend_credit_ctrl #(
  parameter int          W      = 5,
  parameter logic [1:0]  OP_ADD = 2'b00,
  parameter logic [1:0]  OP_SUB = 2'b01,
  parameter logic [1:0]  OP_NOP = 2'b11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         coin_valid,
  input  logic [W-1:0] coin_value,
  input  logic         sel_valid,
  input  logic [W-1:0] sel_price,
  input  logic         cancel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_equal,
  input  logic         alu_greater,
  output logic [W-1:0] credit,
  output logic         busy,
  output logic         vend,
  output logic         insufficient,
  output logic         coin_reject,
  output logic         change_valid,
  output logic [W-1:0] change_amount
);

  typedef enum logic [2:0] {IDLE, ADD, CMP, SUB, REFUND} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] op_reg, op_nxt;
  logic [W-1:0] credit_nxt;
  logic         vend_nxt, insufficient_nxt, coin_reject_nxt, change_valid_nxt;
  logic [W-1:0] change_amount_nxt;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt         = state;
    op_nxt            = op_reg;
    credit_nxt        = credit;
    vend_nxt          = 1'b0;
    insufficient_nxt  = 1'b0;
    coin_reject_nxt   = 1'b0;
    change_valid_nxt  = 1'b0;
    change_amount_nxt = '0;
    alu_a             = '0;
    alu_b             = '0;
    alu_op            = OP_NOP;
    case (state)
      IDLE: begin
        if (cancel) begin
          state_nxt = REFUND;
        end else if (sel_valid) begin
          state_nxt = CMP;
          op_nxt    = sel_price;
        end else if (coin_valid) begin
          state_nxt = ADD;
          op_nxt    = coin_value;
        end
      end
      ADD: begin
        alu_a     = credit;
        alu_b     = op_reg;
        alu_op    = OP_ADD;
        state_nxt = IDLE;
        // A sum smaller than the old credit can only mean the adder wrapped.
        if (alu_result < credit) begin
          coin_reject_nxt   = 1'b1;
          change_amount_nxt = op_reg;
        end else begin
          credit_nxt = alu_result;
        end
      end
      CMP: begin
        alu_a  = credit;
        alu_b  = op_reg;
        alu_op = OP_NOP;
        if (alu_equal || alu_greater) begin
          state_nxt = SUB;
        end else begin
          state_nxt        = IDLE;
          insufficient_nxt = 1'b1;
        end
      end
      SUB: begin
        alu_a      = credit;
        alu_b      = op_reg;
        alu_op     = OP_SUB;
        state_nxt  = IDLE;
        credit_nxt = alu_result;
        vend_nxt   = 1'b1;
      end
      REFUND: begin
        alu_a     = credit;
        alu_b     = '0;
        alu_op    = OP_NOP;
        state_nxt = IDLE;
        if (!alu_equal) begin
          change_valid_nxt  = 1'b1;
          change_amount_nxt = credit;
          credit_nxt        = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_reg        <= '0;
      credit        <= '0;
      vend          <= 1'b0;
      insufficient  <= 1'b0;
      coin_reject   <= 1'b0;
      change_valid  <= 1'b0;
      change_amount <= '0;
    end else begin
      state         <= state_nxt;
      op_reg        <= op_nxt;
      credit        <= credit_nxt;
      vend          <= vend_nxt;
      insufficient  <= insufficient_nxt;
      coin_reject   <= coin_reject_nxt;
      change_valid  <= change_valid_nxt;
      change_amount <= change_amount_nxt;
    end
  end

endmodule
